// File: rtl/debug_snapshot_serializer.sv
// Captures a wide debug vector in one cycle and streams it out byte by byte
// over a valid/ready interface, with abort and completion signalling.
//
//   state | meaning
//   IDLE  | waiting for i_start; o_byte_cnt keeps the last stream's count
//   SEND  | presenting one byte per transfer from the capture shift register
//   DONE  | one-cycle o_done pulse after the last byte has transferred
module debug_snapshot_serializer #(
    parameter int NB_DATA   = 341,
    parameter bit MSB_FIRST = 1'b1,
    parameter int NB_CNT    = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_tx_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_CNT-1:0]  o_byte_cnt
);

    localparam int N_BYTES = (NB_DATA + 7) / 8;
    localparam int NB_SR   = N_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [NB_SR-1:0]   sr, sr_nxt, sr_load;
    logic [NB_CNT-1:0]  cnt, cnt_nxt;
    logic               last_byte;

    // Zero-extend the capture so the padding bits are always 0.
    always_comb begin
        sr_load                = '0;
        sr_load[NB_DATA-1:0]   = i_data;
    end

    assign last_byte = (cnt == NB_CNT'(N_BYTES - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    state_nxt = SEND;
                    sr_nxt    = sr_load;
                    cnt_nxt   = '0;
                end
            end
            SEND: begin
                // Abort takes priority, even over the final transfer.
                if (i_abort) begin
                    state_nxt = IDLE;
                end else if (i_tx_ready) begin
                    sr_nxt  = MSB_FIRST ? (sr << 8) : (sr >> 8);
                    cnt_nxt = cnt + NB_CNT'(1);
                    if (last_byte) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    generate
        if (MSB_FIRST) begin : g_msb
            assign o_tx_data = sr[NB_SR-1 -: 8];
        end else begin : g_lsb
            assign o_tx_data = sr[7:0];
        end
    endgenerate

    assign o_tx_valid = (state == SEND);
    assign o_busy     = (state != IDLE);
    assign o_done     = (state == DONE);
    assign o_byte_cnt = cnt;

endmodule
